// File: rtl/seq_counter_mod.sv
// Parametrised modulo sequence counter over LOW..HIGH with enable, direction,
// range-checked parallel load and wrap/terminal-count flags. SEQCNT_WRAPCNT_EN adds wrap_cnt.
module seq_counter_mod #(
  parameter int WIDTH = 3,
  parameter int LOW   = 1,
  parameter int HIGH  = 5,
  parameter int WRAPW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
`ifdef SEQCNT_WRAPCNT_EN
  ,
  output logic [WRAPW-1:0] wrap_cnt
`endif
);

  localparam logic [WIDTH-1:0] LOW_V  = WIDTH'(LOW);
  localparam logic [WIDTH-1:0] HIGH_V = WIDTH'(HIGH);

  if (LOW < 0 || LOW > HIGH || longint'(HIGH) > ((longint'(1) << WIDTH) - 1)) begin : g_bad_range
    $error("seq_counter_mod: illegal LOW/HIGH for WIDTH");
  end
  if (WRAPW < 1) begin : g_bad_wrapw
    $error("seq_counter_mod: WRAPW must be at least 1");
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             load_err_q, load_err_d;

  always_comb begin
    count_d    = count_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      if (load_val >= LOW_V && load_val <= HIGH_V) begin
        count_d = load_val;
      end else begin
        count_d    = LOW_V;
        load_err_d = 1'b1;
      end
    end else if (en) begin
      // Limit test precedes the +/-1, so the arithmetic never overflows WIDTH.
      if (up) begin
        if (count_q == HIGH_V) begin
          count_d = LOW_V;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        if (count_q == LOW_V) begin
          count_d = HIGH_V;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= LOW_V;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

`ifdef SEQCNT_WRAPCNT_EN
  logic [WRAPW-1:0] wrap_cnt_q, wrap_cnt_d;

  always_comb begin
    wrap_cnt_d = wrap_cnt_q;
    if (wrap_d && wrap_cnt_q != '1) begin
      wrap_cnt_d = wrap_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_cnt_q <= '0;
    end else begin
      wrap_cnt_q <= wrap_cnt_d;
    end
  end

  assign wrap_cnt = wrap_cnt_q;
`endif

  assign count    = count_q;
  assign wrap     = wrap_q;
  assign load_err = load_err_q;
  assign tc       = up ? (count_q == HIGH_V) : (count_q == LOW_V);

endmodule
